// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder: computes {cout, sum} = op_a + op_b + cin using a single
// full-adder bit-slice and one carry flip-flop, processing one bit per clock,
// LSB first. A three-state FSM (IDLE -> SHIFT -> DONE -> IDLE) sequences the
// operation; an addition takes exactly WIDTH SHIFT cycles followed by a
// one-cycle DONE.
//
// Parameters
//   WIDTH  operand/result width in bits (1..32)
//
// Ports
//   clk    in   clock, all state updates on the rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request to begin an addition, sampled only in IDLE
//   op_a   in   operand A, captured when start is accepted
//   op_b   in   operand B, captured when start is accepted
//   cin    in   carry-in, captured when start is accepted
//   busy   out  high while the addition is in progress (SHIFT)
//   done   out  one-cycle pulse; sum/cout are valid from this cycle on
//   sum    out  registered result, bit i has weight 2^i
//   cout   out  registered final carry-out
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The bit counter only ever needs to reach WIDTH-1; keep it at least one
    // bit wide so WIDTH=1 still elaborates cleanly.
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             carry_reg, carry_next;
    logic             cout_reg, cout_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    // Full-adder bit-slice working on the current LSBs and the carry flop.
    logic bit_sum;
    logic bit_carry;

    assign bit_sum   = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign bit_carry = (a_reg[0] & b_reg[0]) | ((a_reg[0] ^ b_reg[0]) & carry_reg);

    // Right-shifted views of the operand and result registers. Operands shift
    // in zeros; the result register takes the new sum bit at its MSB so that
    // after WIDTH shifts the first (LSB) result bit has landed in bit 0.
    // Written per bit so that WIDTH=1 degenerates to an empty loop.
    logic [WIDTH-1:0] a_shr;
    logic [WIDTH-1:0] b_shr;
    logic [WIDTH-1:0] sum_shr;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign a_shr[gi]   = a_reg[gi+1];
            assign b_shr[gi]   = b_reg[gi+1];
            assign sum_shr[gi] = sum_reg[gi+1];
        end
    endgenerate

    assign a_shr[WIDTH-1]   = 1'b0;
    assign b_shr[WIDTH-1]   = 1'b0;
    assign sum_shr[WIDTH-1] = bit_sum;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            cnt_reg   <= cnt_next;
            carry_reg <= carry_next;
            cout_reg  <= cout_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        cnt_next   = cnt_reg;
        carry_next = carry_reg;
        cout_next  = cout_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                    a_next     = op_a;
                    b_next     = op_b;
                    carry_next = cin;
                    cnt_next   = '0;
                    sum_next   = '0;
                end
            end

            SHIFT: begin
                a_next     = a_shr;
                b_next     = b_shr;
                sum_next   = sum_shr;
                carry_next = bit_carry;
                cnt_next   = cnt_reg + CNT_ONE;
                // The bit being processed this cycle is the last one, so the
                // carry it produces is the final carry-out.
                if (cnt_reg == LAST_BIT) begin
                    state_next = DONE;
                    cout_next  = bit_carry;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status flags are decoded from the next state and registered, so the
    // outputs come straight from flops and track the state register exactly.
    always_comb begin
        busy_next = (state_next == SHIFT);
        done_next = (state_next == DONE);
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder. Four instances (WIDTH = 1, 8, 16, 32)
// share one operand bus and reset; each has its own start. Expected results
// are computed with integer addition, pushed to a queue when a start is
// accepted and popped when the instance pulses done.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  start_v;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cin;

    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [3:0]  cout_v;
    logic [0:0]  sum1;
    logic [7:0]  sum8;
    logic [15:0] sum16;
    logic [31:0] sum32;
    logic [31:0] sum_v [4];

    int widths [4] = '{1, 8, 16, 32};

    logic [32:0] exp_q [$];

    int checks = 0;
    int passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_adder #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .op_a(op_a[0:0]), .op_b(op_b[0:0]), .cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum1), .cout(cout_v[0])
    );

    serial_adder #(.WIDTH(8)) dut_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .op_a(op_a[7:0]), .op_b(op_b[7:0]), .cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum8), .cout(cout_v[1])
    );

    serial_adder #(.WIDTH(16)) dut_w16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .op_a(op_a[15:0]), .op_b(op_b[15:0]), .cin(cin),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum16), .cout(cout_v[2])
    );

    serial_adder #(.WIDTH(32)) dut_w32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]),
        .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy_v[3]), .done(done_v[3]), .sum(sum32), .cout(cout_v[3])
    );

    always_comb begin
        sum_v[0] = {31'd0, sum1};
        sum_v[1] = {24'd0, sum8};
        sum_v[2] = {16'd0, sum16};
        sum_v[3] = sum32;
    end

    // Hard stop in case something never returns.
    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", passed, checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mask_of(input int wd);
        return (wd >= 32) ? 32'hFFFF_FFFF : ((32'd1 << wd) - 32'd1);
    endfunction

    // Reference model: {cout, sum} = a + b + c, truncated to the instance width.
    function automatic logic [32:0] ref_add(input int wd, input logic [31:0] a,
                                            input logic [31:0] b, input logic c);
        logic [32:0] full;
        logic [31:0] m;
        m    = mask_of(wd);
        full = {1'b0, a & m} + {1'b0, b & m} + {32'd0, c};
        return {full[wd], full[31:0] & m};
    endfunction

    // One complete addition on instance k. With noise set, start and the
    // operand bus are randomised after acceptance; neither may disturb the
    // operation in flight.
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input bit noise, input string name);
        int          wd;
        int          edges;
        int          busy_cycles;
        bit          seen;
        logic [32:0] exp;
        logic [32:0] got;
        wd = widths[k];
        exp_q.push_back(ref_add(wd, a, b, c));
        op_a       = a & mask_of(wd);
        op_b       = b & mask_of(wd);
        cin        = c;
        start_v[k] = 1'b1;
        step();
        edges       = 1;
        busy_cycles = 0;
        seen        = 1'b0;
        start_v[k]  = noise ? 1'($urandom) : 1'b0;
        op_a        = $urandom;
        op_b        = $urandom;
        cin         = 1'($urandom);
        while (edges < wd + 10) begin
            if (done_v[k]) begin
                seen = 1'b1;
                break;
            end
            if (busy_v[k]) busy_cycles++;
            step();
            edges++;
            start_v[k] = noise ? 1'($urandom) : 1'b0;
            op_a       = $urandom;
            op_b       = $urandom;
            cin        = 1'($urandom);
        end
        start_v[k] = 1'b0;
        exp = exp_q.pop_front();

        checks++;
        if (seen !== 1'b1)
            $display("FAIL %s done_seen: got %0b expected 1 (W=%0d)", name, seen, wd);
        else passed++;

        checks++;
        if (edges !== wd + 1)
            $display("FAIL %s latency: got %0d edges expected %0d (W=%0d)", name, edges, wd + 1, wd);
        else passed++;

        checks++;
        if (busy_cycles !== wd)
            $display("FAIL %s busy_cycles: got %0d expected %0d (W=%0d)", name, busy_cycles, wd, wd);
        else passed++;

        got = {cout_v[k], sum_v[k]};
        checks++;
        if (got !== exp)
            $display("FAIL %s result: got cout=%0b sum=%h expected cout=%0b sum=%h (W=%0d)",
                     name, got[32], got[31:0], exp[32], exp[31:0], wd);
        else passed++;

        // DONE lasts one cycle; the result must persist into IDLE.
        step();
        got = {cout_v[k], sum_v[k]};
        checks++;
        if ({done_v[k], busy_v[k], got} !== {2'b00, exp})
            $display("FAIL %s after_done: got done=%0b busy=%0b cout=%0b sum=%h expected done=0 busy=0 cout=%0b sum=%h",
                     name, done_v[k], busy_v[k], got[32], got[31:0], exp[32], exp[31:0]);
        else passed++;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({busy_v[k], done_v[k], cout_v[k], sum_v[k]} !== 35'd0)
                $display("FAIL reset_state[%0d]: got busy=%0b done=%0b cout=%0b sum=%h expected all 0",
                         k, busy_v[k], done_v[k], cout_v[k], sum_v[k]);
            else passed++;
        end
    endtask

    task automatic test_basic();
        run_op(1, 32'h05, 32'h03, 1'b0, 1'b0, "add_05_03");
        run_op(1, 32'hFF, 32'h01, 1'b0, 1'b0, "add_FF_01");
        run_op(1, 32'hFF, 32'hFF, 1'b1, 1'b0, "add_FF_FF_c1");
        run_op(1, 32'h00, 32'h00, 1'b0, 1'b0, "add_zero");
        run_op(1, 32'hA5, 32'h5A, 1'b1, 1'b1, "add_noise");
    endtask

    task automatic test_hold();
        logic [32:0] exp;
        run_op(1, 32'h3C, 32'h4D, 1'b1, 1'b0, "hold_op");
        exp = ref_add(8, 32'h3C, 32'h4D, 1'b1);
        for (int i = 0; i < 5; i++) begin
            op_a = $urandom;
            op_b = $urandom;
            cin  = 1'($urandom);
            step();
            checks++;
            if ({busy_v[1], cout_v[1], sum_v[1]} !== {1'b0, exp})
                $display("FAIL idle_hold[%0d]: got busy=%0b cout=%0b sum=%h expected busy=0 cout=%0b sum=%h",
                         i, busy_v[1], cout_v[1], sum_v[1], exp[32], exp[31:0]);
            else passed++;
        end
    endtask

    task automatic test_width1_exhaustive();
        for (int i = 0; i < 8; i++) begin
            run_op(0, 32'(i & 1), 32'((i >> 1) & 1), 1'((i >> 2) & 1), 1'b0,
                   $sformatf("w1_fa_%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        int          n_ops;
        int          accepted;
        int          completed;
        int          cyc;
        bit          prev_busy;
        bit          prev_done;
        logic [31:0] a_d;
        logic [31:0] b_d;
        logic        c_d;
        logic [32:0] exp;
        logic [32:0] got;
        n_ops     = 20;
        accepted  = 0;
        completed = 0;
        cyc       = 0;
        exp_q.delete();
        prev_busy = busy_v[1];
        prev_done = done_v[1];
        while ((accepted < n_ops || exp_q.size() > 0) && cyc < n_ops * 12 + 40) begin
            start_v[1] = (accepted < n_ops);
            a_d  = $urandom;
            b_d  = $urandom;
            c_d  = 1'($urandom);
            op_a = a_d;
            op_b = b_d;
            cin  = c_d;
            step();
            cyc++;
            if (prev_done) begin
                checks++;
                if ({busy_v[1], done_v[1]} !== 2'b00)
                    $display("FAIL b2b_idle_gap: got busy=%0b done=%0b expected 0 0 after done",
                             busy_v[1], done_v[1]);
                else passed++;
            end
            if (busy_v[1] && !prev_busy) begin
                exp_q.push_back(ref_add(8, a_d, b_d, c_d));
                accepted++;
            end
            if (done_v[1]) begin
                got = {cout_v[1], sum_v[1]};
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_result[%0d]: done with no accepted start, got sum=%h", completed, got[31:0]);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp)
                        $display("FAIL b2b_result[%0d]: got cout=%0b sum=%h expected cout=%0b sum=%h",
                                 completed, got[32], got[31:0], exp[32], exp[31:0]);
                    else passed++;
                end
                completed++;
            end
            prev_busy = busy_v[1];
            prev_done = done_v[1];
        end
        start_v[1] = 1'b0;
        checks++;
        if (completed !== n_ops || exp_q.size() != 0)
            $display("FAIL b2b_complete: got %0d completed (%0d pending) expected %0d",
                     completed, exp_q.size(), n_ops);
        else passed++;
        exp_q.delete();
        step();
        step();
    endtask

    task automatic test_reset_mid_shift();
        op_a       = 32'hAA;
        op_b       = 32'h55;
        cin        = 1'b0;
        start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        repeat (3) step();
        checks++;
        if (busy_v[1] !== 1'b1)
            $display("FAIL rst_mid_busy: got busy=%0b expected 1 before reset", busy_v[1]);
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_v[1], done_v[1], cout_v[1], sum_v[1]} !== 35'd0)
            $display("FAIL rst_mid_immediate: got busy=%0b done=%0b cout=%0b sum=%h expected all 0",
                     busy_v[1], done_v[1], cout_v[1], sum_v[1]);
        else passed++;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if ({busy_v[1], done_v[1], sum_v[1]} !== 34'd0)
                $display("FAIL rst_mid_idle[%0d]: got busy=%0b done=%0b sum=%h expected 0 0 0",
                         i, busy_v[1], done_v[1], sum_v[1]);
            else passed++;
        end
        run_op(1, 32'h10, 32'h20, 1'b0, 1'b0, "rst_recover");
    endtask

    task automatic test_regression();
        int          n_ops;
        logic [31:0] a;
        logic [31:0] b;
        for (int k = 0; k < 4; k++) begin
            n_ops = (k == 0) ? 200 : (k == 1) ? 400 : (k == 2) ? 200 : 150;
            for (int i = 0; i < n_ops; i++) begin
                a = $urandom;
                b = $urandom;
                if (i % 8 == 0) a = 32'hFFFF_FFFF;
                if (i % 16 == 0) b = 32'hFFFF_FFFF;
                run_op(k, a, b, 1'($urandom), 1'b1, $sformatf("regress_w%0d_%0d", widths[k], i));
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_v = 4'b0000;
        op_a    = 32'd0;
        op_b    = 32'd0;
        cin     = 1'b0;
        repeat (3) step();
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_hold();
        test_width1_exhaustive();
        test_back_to_back();
        test_reset_mid_shift();
        test_regression();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
